// File: rtl/zion_mult_seq.sv
// Multi-cycle sign-magnitude shift-add multiplier that retires BITS_PER_CYCLE multiplier bits per clock.
// Define ZION_MULT_EARLY_TERM_EN to leave CALC as soon as the remaining multiplier bits are all zero.
module zion_mult_seq #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [DATA_WIDTH-1:0] iS1,
  input  logic [DATA_WIDTH-1:0] iS2,
  input  logic                  iS1Sign,
  input  logic                  iS2Sign,
  input  logic [1:0]            iMultOpEn,
  input  logic                  iFlush,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [DATA_WIDTH-1:0] oResult
);

  localparam int W     = DATA_WIDTH;
  localparam int B     = BITS_PER_CYCLE;
  localparam int N     = W / B;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (!(B == 1 || B == 2 || B == 4) || (W % B) != 0) begin : gBadParam
      $error("zion_mult_seq: BITS_PER_CYCLE must be 1, 2 or 4 and divide DATA_WIDTH");
    end
  endgenerate

  logic [1:0]       stateReg;
  logic [CNT_W-1:0] cntReg;
  logic [2*W-1:0]   mcandReg;
  logic [W-1:0]     mplierReg;
  logic             signReg;
  logic [1:0]       opEnReg;
  logic [2*W-1:0]   accReg;
  logic [W-1:0]     resultReg;

  logic             s1Neg;
  logic             s2Neg;
  logic [W-1:0]     s1Mag;
  logic [W-1:0]     s2Mag;
  logic [2*W-1:0]   ppTerm [B];
  logic [2*W-1:0]   ppSum;
  logic [2*W-1:0]   accSum;
  logic [2*W-1:0]   finalProduct;
  logic [W-1:0]     mplierShift;
  logic             lastStep;

  assign s1Neg = iS1Sign & iS1[W-1];
  assign s2Neg = iS2Sign & iS2[W-1];
  assign s1Mag = s1Neg ? (~iS1 + W'(1)) : iS1;
  assign s2Mag = s2Neg ? (~iS2 + W'(1)) : iS2;

  // One shifted copy of the multiplicand per multiplier bit retired this cycle.
  generate
    for (genvar gi = 0; gi < B; gi++) begin : gPartial
      assign ppTerm[gi] = mplierReg[gi] ? (mcandReg << gi) : '0;
    end
  endgenerate

  always_comb begin
    ppSum = '0;
    for (int i = 0; i < B; i++) begin
      ppSum = ppSum + ppTerm[i];
    end
  end

  assign accSum       = accReg + ppSum;
  assign finalProduct = signReg ? (~accSum + (2*W)'(1)) : accSum;
  assign mplierShift  = mplierReg >> B;

`ifdef ZION_MULT_EARLY_TERM_EN
  assign lastStep = (cntReg == '0) || (mplierShift == '0);
`else
  assign lastStep = (cntReg == '0);
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateReg  <= IDLE;
      cntReg    <= '0;
      mcandReg  <= '0;
      mplierReg <= '0;
      signReg   <= 1'b0;
      opEnReg   <= 2'b00;
      accReg    <= '0;
      resultReg <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (!iFlush && iValid) begin
            stateReg  <= CALC;
            cntReg    <= CNT_W'(N - 1);
            mcandReg  <= {{W{1'b0}}, s1Mag};
            mplierReg <= s2Mag;
            signReg   <= s1Neg ^ s2Neg;
            opEnReg   <= iMultOpEn;
            accReg    <= '0;
          end
        end
        CALC: begin
          if (iFlush) begin
            stateReg <= IDLE;
          end else begin
            accReg    <= accSum;
            mcandReg  <= mcandReg << B;
            mplierReg <= mplierShift;
            cntReg    <= cntReg - CNT_W'(1);
            if (lastStep) begin
              stateReg  <= DONE;
              resultReg <= (finalProduct[2*W-1:W] & {W{opEnReg[0]}}) |
                           (finalProduct[W-1:0]   & {W{opEnReg[1]}});
            end
          end
        end
        DONE: begin
          if (iFlush || iReady) begin
            stateReg <= IDLE;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign oReady  = (stateReg == IDLE);
  assign oValid  = (stateReg == DONE);
  assign oResult = resultReg;

endmodule

// File: tb/tb_zion_mult_seq.sv
// Self-checking bench for zion_mult_seq: directed cases on the B=2 instance, then random
// operands on B=1/2/4 instances checked against a 64-bit arithmetic reference model.
module tb_zion_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld   [3];
  logic        rdyO  [3];
  logic [31:0] s1    [3];
  logic [31:0] s2    [3];
  logic        s1Sg  [3];
  logic        s2Sg  [3];
  logic [1:0]  opEn  [3];
  logic        flush [3];
  logic        vldO  [3];
  logic        rdyI  [3];
  logic [31:0] resO  [3];

  int compCnt = 0;
  int errCnt  = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : gDut
    zion_mult_seq #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1 << gi)) dut (
      .iClk(clk), .iRst(rst), .iValid(vld[gi]), .oReady(rdyO[gi]),
      .iS1(s1[gi]), .iS2(s2[gi]), .iS1Sign(s1Sg[gi]), .iS2Sign(s2Sg[gi]),
      .iMultOpEn(opEn[gi]), .iFlush(flush[gi]), .oValid(vldO[gi]),
      .iReady(rdyI[gi]), .oResult(resO[gi])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full 64-bit product from plain signed/unsigned arithmetic, then half select.
  function automatic logic [31:0] refResult(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb, input logic [1:0] en);
    longint pa, pb;
    logic [63:0] p;
    pa = sa ? longint'($signed(a)) : longint'(a);
    pb = sb ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    return (p[63:32] & {32{en[0]}}) | (p[31:0] & {32{en[1]}});
  endfunction

  // Number of clock edges from the accept edge until oValid is seen high (= CALC cycles).
  function automatic int refCycles(input logic [31:0] b, input logic sb, input int bpc);
`ifdef ZION_MULT_EARLY_TERM_EN
    longint m;
    int len, c;
    m = sb ? longint'($signed(b)) : longint'(b);
    if (m < 0) m = -m;
    len = 0;
    while ((m >> len) != 0) len++;
    c = (len + bpc - 1) / bpc;
    return (c == 0) ? 1 : c;
`else
    return 32 / bpc;
`endif
  endfunction

  task automatic runOp(input int k, input logic [31:0] a, input logic [31:0] b, input logic sa,
                       input logic sb, input logic [1:0] en, output logic [31:0] res, output int cyc);
    s1[k] = a; s2[k] = b; s1Sg[k] = sa; s2Sg[k] = sb; opEn[k] = en; vld[k] = 1'b1;
    @(posedge clk); #1;
    vld[k] = 1'b0;
    s1[k] = $urandom; s2[k] = $urandom; opEn[k] = 2'($urandom);
    cyc = 0;
    while (!vldO[k] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = resO[k];
  endtask

  task automatic finishOp(input int k, input string tag);
    rdyI[k] = 1'b1;
    @(posedge clk); #1;
    rdyI[k] = 1'b0;
    check({tag, "_rdyAfter"}, 64'(rdyO[k]), 64'd1);
    check({tag, "_vldAfter"}, 64'(vldO[k]), 64'd0);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic [1:0] en, input logic [31:0] exp);
    logic [31:0] res;
    int cyc;
    runOp(1, a, b, sa, sb, en, res, cyc);
    check(tag, 64'(res), 64'(exp));
    check({tag, "_lat"}, 64'(cyc), 64'(refCycles(b, sb, 2)));
    finishOp(1, tag);
    $display("op %s: %h x %h -> %h (edges %0d)", tag, a, b, res, cyc);
  endtask

  task automatic watchNoValid(input int k, input int n, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      seen = seen | vldO[k];
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] res, a, b, hold;
    logic sa, sb;
    logic [1:0] en;
    int cyc;

    for (int k = 0; k < 3; k++) begin
      vld[k] = 0; s1[k] = 0; s2[k] = 0; s1Sg[k] = 0; s2Sg[k] = 0;
      opEn[k] = 0; flush[k] = 0; rdyI[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", 64'(rdyO[k]), 64'd1);
      check("rst_valid", 64'(vldO[k]), 64'd0);
      check("rst_result", 64'(resO[k]), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    directed("u7x6_lo",   32'd7,          32'd6,          1'b0, 1'b0, 2'b10, 32'd42);
    directed("sm3x5_lo",  32'hFFFFFFFD,   32'd5,          1'b1, 1'b1, 2'b10, 32'hFFFFFFF1);
    directed("sm3x5_hi",  32'hFFFFFFFD,   32'd5,          1'b1, 1'b1, 2'b01, 32'hFFFFFFFF);
    directed("sm3x5_or",  32'hFFFFFFFD,   32'd5,          1'b1, 1'b1, 2'b11, 32'hFFFFFFFF);
    directed("sm3x5_off", 32'hFFFFFFFD,   32'd5,          1'b1, 1'b1, 2'b00, 32'h0);
    directed("smin_lo",   32'h80000000,   32'hFFFFFFFF,   1'b1, 1'b1, 2'b10, 32'h80000000);
    directed("smin_hi",   32'h80000000,   32'hFFFFFFFF,   1'b1, 1'b1, 2'b01, 32'h00000000);
    directed("umax_hi",   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 1'b0, 2'b01, 32'hFFFFFFFE);
    directed("umax_lo",   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 1'b0, 2'b10, 32'h00000001);
    directed("zero_mul",  32'h12345678,   32'd0,          1'b1, 1'b1, 2'b11, 32'h0);

    // Consumer stall in DONE, with new operands offered that must be ignored.
    runOp(1, 32'd5, 32'd9, 1'b0, 1'b0, 2'b10, hold, cyc);
    check("stall_first", 64'(hold), 64'd45);
    for (int i = 0; i < 5; i++) begin
      vld[1] = 1'b1; s1[1] = $urandom; s2[1] = $urandom; opEn[1] = 2'b11;
      @(posedge clk); #1;
      check("stall_valid", 64'(vldO[1]), 64'd1);
      check("stall_result", 64'(resO[1]), 64'(hold));
      check("stall_ready", 64'(rdyO[1]), 64'd0);
    end
    vld[1] = 1'b0;
    finishOp(1, "stall");
    watchNoValid(1, 20, "stall_noAccept");
    $display("op stall: result %h held 5 cycles", hold);

    // Flush in the 4th CALC cycle.
    s1[1] = 32'd11; s2[1] = 32'd13; s1Sg[1] = 0; s2Sg[1] = 0; opEn[1] = 2'b10; vld[1] = 1'b1;
    @(posedge clk); #1;
    vld[1] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    flush[1] = 1'b1;
    @(posedge clk); #1;
    flush[1] = 1'b0;
    check("flushCalc_ready", 64'(rdyO[1]), 64'd1);
    check("flushCalc_valid", 64'(vldO[1]), 64'd0);
    watchNoValid(1, 20, "flushCalc_noValid");
    $display("op flushCalc: aborted");

    // Flush while DONE discards the result.
    runOp(1, 32'd3, 32'd3, 1'b0, 1'b0, 2'b10, res, cyc);
    check("flushDone_pre", 64'(res), 64'd9);
    flush[1] = 1'b1;
    @(posedge clk); #1;
    flush[1] = 1'b0;
    check("flushDone_valid", 64'(vldO[1]), 64'd0);
    check("flushDone_ready", 64'(rdyO[1]), 64'd1);
    $display("op flushDone: discarded %h", res);

    // Flush beats iValid in IDLE.
    s1[1] = 32'd4; s2[1] = 32'd4; vld[1] = 1'b1; flush[1] = 1'b1;
    @(posedge clk); #1;
    vld[1] = 1'b0; flush[1] = 1'b0;
    check("flushIdle_ready", 64'(rdyO[1]), 64'd1);
    watchNoValid(1, 20, "flushIdle_noValid");
    $display("op flushIdle: no accept");

    // Reset in the 8th CALC cycle.
    s1[1] = 32'd100; s2[1] = 32'hFFFFFFFF; s1Sg[1] = 0; s2Sg[1] = 0; opEn[1] = 2'b10; vld[1] = 1'b1;
    @(posedge clk); #1;
    vld[1] = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midRst_ready", 64'(rdyO[1]), 64'd1);
    check("midRst_valid", 64'(vldO[1]), 64'd0);
    check("midRst_result", 64'(resO[1]), 64'd0);
    watchNoValid(1, 20, "midRst_noValid");
    $display("op midReset: cleared");
    directed("after_2x3", 32'd2, 32'd3, 1'b0, 1'b0, 2'b10, 32'd6);

    // Random operands on every BITS_PER_CYCLE variant.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 350; i++) begin
        a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
        b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
        if ($urandom_range(0, 9) == 0) b = -b;
        sa = 1'($urandom); sb = 1'($urandom); en = 2'($urandom);
        runOp(k, a, b, sa, sb, en, res, cyc);
        check("rand_result", 64'(res), 64'(refResult(a, b, sa, sb, en)));
        check("rand_lat", 64'(cyc), 64'(refCycles(b, sb, 1 << k)));
        finishOp(k, "rand");
        $display("rand B=%0d: %h(%0d) x %h(%0d) en=%b -> %h edges=%0d",
                 1 << k, a, sa, b, sb, en, res, cyc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
    $finish;
  end

endmodule
